// File: rtl/cnn_layer_accel_job_ctrl.sv
// Job-control responder for one cnn_layer_accel_quad: accepts a job, fetches the
// input volume into the row buffers, starts the core and reports completion.
module cnn_layer_accel_job_ctrl #(
  parameter int C_PIXEL_WIDTH    = 128,
  parameter int C_BEAT_CNT_WIDTH = 20
) (
  input  logic                     clk_if,
  input  logic                     rst,
  input  logic                     job_start,
  output logic                     job_accept,
  input  logic [127:0]             job_parameters,
  output logic                     job_fetch_request,
  input  logic                     job_fetch_ack,
  output logic                     job_fetch_complete,
  output logic                     job_complete,
  input  logic                     job_complete_ack,
  input  logic                     pixel_valid,
  output logic                     pixel_ready,
  input  logic [C_PIXEL_WIDTH-1:0] pixel_data,
  input  logic                     buf_full,
  output logic                     pix_wr_en,
  output logic [C_PIXEL_WIDTH-1:0] pix_wr_data,
  output logic [9:0]               cfg_rows,
  output logic [9:0]               cfg_cols,
  output logic [3:0]               cfg_kernel_size,
  output logic [3:0]               cfg_stride,
  output logic [3:0]               cfg_padding,
  output logic [15:0]              cfg_num_kernels,
  output logic                     core_start,
  input  logic                     core_done
);

  typedef enum logic [2:0] {
    IDLE,
    ACCEPT,
    FETCH_REQ,
    FETCH_DATA,
    FETCH_DONE,
    RUN,
    COMPLETE
  } state_t;

  state_t                      state_reg;
  logic [C_BEAT_CNT_WIDTH-1:0] beats_expected_reg;
  logic [C_BEAT_CNT_WIDTH-1:0] beat_cnt_reg;
  logic [C_BEAT_CNT_WIDTH-1:0] beat_cnt_next;
  logic                        beat_xfer;
  logic                        reserved_unused;

  // Reserved parameter bits are deliberately dropped.
  assign reserved_unused = ^job_parameters[127:48];

  // Ready follows backpressure within the same cycle so no beat is taken while full.
  assign pixel_ready   = (state_reg == FETCH_DATA) && !buf_full;
  assign beat_xfer     = pixel_valid && pixel_ready;
  assign beat_cnt_next = beat_cnt_reg + C_BEAT_CNT_WIDTH'(1);

  always_ff @(posedge clk_if or posedge rst) begin
    if (rst) begin
      state_reg          <= IDLE;
      beats_expected_reg <= '0;
      beat_cnt_reg       <= '0;
      job_accept         <= 1'b0;
      job_fetch_request  <= 1'b0;
      job_fetch_complete <= 1'b0;
      job_complete       <= 1'b0;
      pix_wr_en          <= 1'b0;
      pix_wr_data        <= '0;
      cfg_rows           <= '0;
      cfg_cols           <= '0;
      cfg_kernel_size    <= '0;
      cfg_stride         <= '0;
      cfg_padding        <= '0;
      cfg_num_kernels    <= '0;
      core_start         <= 1'b0;
    end else begin
      job_accept         <= 1'b0;
      job_fetch_complete <= 1'b0;
      core_start         <= 1'b0;
      pix_wr_en          <= 1'b0;

      case (state_reg)
        IDLE: begin
          if (job_start) begin
            cfg_rows           <= job_parameters[9:0];
            cfg_cols           <= job_parameters[19:10];
            cfg_kernel_size    <= job_parameters[23:20];
            cfg_stride         <= job_parameters[27:24];
            cfg_padding        <= job_parameters[31:28];
            cfg_num_kernels    <= job_parameters[47:32];
            beats_expected_reg <= C_BEAT_CNT_WIDTH'(job_parameters[9:0]) *
                                  C_BEAT_CNT_WIDTH'(job_parameters[19:10]);
            job_accept         <= 1'b1;
            state_reg          <= ACCEPT;
          end
        end

        ACCEPT: begin
          // An empty volume has nothing to fetch or convolve.
          if (cfg_rows == 10'd0 || cfg_cols == 10'd0) begin
            job_complete <= 1'b1;
            state_reg    <= COMPLETE;
          end else begin
            job_fetch_request <= 1'b1;
            state_reg         <= FETCH_REQ;
          end
        end

        FETCH_REQ: begin
          if (job_fetch_ack) begin
            job_fetch_request <= 1'b0;
            beat_cnt_reg      <= '0;
            state_reg         <= FETCH_DATA;
          end
        end

        FETCH_DATA: begin
          if (beat_xfer) begin
            pix_wr_en    <= 1'b1;
            pix_wr_data  <= pixel_data;
            beat_cnt_reg <= beat_cnt_next;
            if (beat_cnt_next == beats_expected_reg) begin
              job_fetch_complete <= 1'b1;
              core_start         <= 1'b1;
              state_reg          <= FETCH_DONE;
            end
          end
        end

        FETCH_DONE: begin
          state_reg <= RUN;
        end

        RUN: begin
          if (core_done) begin
            job_complete <= 1'b1;
            state_reg    <= COMPLETE;
          end
        end

        COMPLETE: begin
          if (job_complete_ack) begin
            job_complete <= 1'b0;
            state_reg    <= IDLE;
          end
        end

        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cnn_layer_accel_job_ctrl.sv
// Directed bench for cnn_layer_accel_job_ctrl: normal, backpressured, empty,
// abusive, reset-interrupted and back-to-back jobs.
module tb_cnn_layer_accel_job_ctrl;

  logic         clk_if = 1'b0;
  logic         rst = 1'b1;
  logic         job_start = 1'b0;
  logic         job_accept;
  logic [127:0] job_parameters = '0;
  logic         job_fetch_request;
  logic         job_fetch_ack = 1'b0;
  logic         job_fetch_complete;
  logic         job_complete;
  logic         job_complete_ack = 1'b0;
  logic         pixel_valid = 1'b0;
  logic         pixel_ready;
  logic [127:0] pixel_data = '0;
  logic         buf_full = 1'b0;
  logic         pix_wr_en;
  logic [127:0] pix_wr_data;
  logic [9:0]   cfg_rows;
  logic [9:0]   cfg_cols;
  logic [3:0]   cfg_kernel_size;
  logic [3:0]   cfg_stride;
  logic [3:0]   cfg_padding;
  logic [15:0]  cfg_num_kernels;
  logic         core_start;
  logic         core_done = 1'b0;

  int total = 0;
  int bad = 0;

  cnn_layer_accel_job_ctrl #(
    .C_PIXEL_WIDTH   (128),
    .C_BEAT_CNT_WIDTH(20)
  ) dut (
    .clk_if            (clk_if),
    .rst               (rst),
    .job_start         (job_start),
    .job_accept        (job_accept),
    .job_parameters    (job_parameters),
    .job_fetch_request (job_fetch_request),
    .job_fetch_ack     (job_fetch_ack),
    .job_fetch_complete(job_fetch_complete),
    .job_complete      (job_complete),
    .job_complete_ack  (job_complete_ack),
    .pixel_valid       (pixel_valid),
    .pixel_ready       (pixel_ready),
    .pixel_data        (pixel_data),
    .buf_full          (buf_full),
    .pix_wr_en         (pix_wr_en),
    .pix_wr_data       (pix_wr_data),
    .cfg_rows          (cfg_rows),
    .cfg_cols          (cfg_cols),
    .cfg_kernel_size   (cfg_kernel_size),
    .cfg_stride        (cfg_stride),
    .cfg_padding       (cfg_padding),
    .cfg_num_kernels   (cfg_num_kernels),
    .core_start        (core_start),
    .core_done         (core_done)
  );

  always #5 clk_if = ~clk_if;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_if);
    #1;
  endtask

  function automatic logic [127:0] beat_word(input int i);
    logic [15:0] s;
    s = i[15:0];
    return {8{s}} ^ 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677;
  endfunction

  // Reserved bits are filled with junk that must not affect anything.
  function automatic logic [127:0] make_prm(input logic [9:0] r, input logic [9:0] c,
                                            input logic [3:0] k, input logic [3:0] s,
                                            input logic [3:0] p, input logic [15:0] nk);
    return {80'hFEED_BEEF_CAFE_F00D_A5A5, nk, p, s, k, c, r};
  endfunction

  task automatic do_start(input logic [127:0] prm, input bit hold, input bit zero);
    job_start = 1'b1;
    job_parameters = prm;
    tick();
    if (!hold) job_start = 1'b0;
    chk("job_accept", job_accept, 1'b1);
    chk("cfg_rows", cfg_rows, prm[9:0]);
    chk("cfg_cols", cfg_cols, prm[19:10]);
    chk("cfg_kernel_size", cfg_kernel_size, prm[23:20]);
    chk("cfg_stride", cfg_stride, prm[27:24]);
    chk("cfg_padding", cfg_padding, prm[31:28]);
    chk("cfg_num_kernels", cfg_num_kernels, prm[47:32]);
    tick();
    chk("accept_one_cycle", job_accept, 1'b0);
    chk("fetch_request", job_fetch_request, !zero);
    chk("complete_after_accept", job_complete, zero);
    chk("no_core_start", core_start, 1'b0);
  endtask

  task automatic do_ack();
    tick();
    chk("request_held", job_fetch_request, 1'b1);
    chk("ready_before_ack", pixel_ready, 1'b0);
    job_fetch_ack = 1'b1;
    tick();
    job_fetch_ack = 1'b0;
    chk("request_dropped", job_fetch_request, 1'b0);
  endtask

  task automatic run_fetch(input int n, input bit bp, input int stop_at, input bit spur,
                           output int writes);
    int  sent;
    bit  xfer;
    bit  done;
    sent = 0;
    done = 1'b0;
    for (int cyc = 0; cyc < 6000 && !done; cyc++) begin
      buf_full    = bp && ((cyc / 3) % 2 == 1);
      pixel_valid = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      pixel_data  = beat_word(sent);
      core_done   = spur && (cyc == 5);
      #1;
      chk("pixel_ready", pixel_ready, !buf_full);
      xfer = pixel_valid && !buf_full;
      tick();
      chk("pix_wr_en", pix_wr_en, xfer);
      chk("accept_quiet", job_accept, 1'b0);
      if (xfer) begin
        chk("pix_wr_data", pix_wr_data, beat_word(sent));
        sent++;
      end
      if (stop_at != 0 && sent == stop_at) begin
        done = 1'b1;
      end else if (sent == n) begin
        chk("fetch_complete", job_fetch_complete, 1'b1);
        chk("core_start", core_start, 1'b1);
        done = 1'b1;
      end else begin
        chk("fetch_complete_early", job_fetch_complete, 1'b0);
        chk("core_start_early", core_start, 1'b0);
      end
    end
    chk("fetch_finished_in_budget", done, 1'b1);
    writes      = sent;
    pixel_valid = 1'b0;
    buf_full    = 1'b0;
    core_done   = 1'b0;
  endtask

  task automatic finish_job(input bit spur_ack);
    tick();
    chk("run_pulses_clear", {job_fetch_complete, core_start, job_complete}, 3'b000);
    chk("ready_in_run", pixel_ready, 1'b0);
    if (spur_ack) begin
      job_complete_ack = 1'b1;
      tick();
      job_complete_ack = 1'b0;
      chk("spurious_ack_ignored", job_complete, 1'b0);
    end
    tick();
    chk("wait_core_done", job_complete, 1'b0);
    core_done = 1'b1;
    tick();
    core_done = 1'b0;
    chk("job_complete", job_complete, 1'b1);
    tick();
    chk("complete_held", job_complete, 1'b1);
    chk("no_accept_in_complete", job_accept, 1'b0);
    job_complete_ack = 1'b1;
    tick();
    job_complete_ack = 1'b0;
    chk("complete_cleared", job_complete, 1'b0);
    chk("no_accept_at_ack", job_accept, 1'b0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk(tag, {job_accept, job_fetch_request, job_fetch_complete, job_complete,
              pixel_ready, pix_wr_en, core_start}, 7'd0);
    chk({tag, "_wr_data"}, pix_wr_data, 128'd0);
    chk({tag, "_cfg"}, {cfg_rows, cfg_cols, cfg_kernel_size, cfg_stride, cfg_padding,
                        cfg_num_kernels}, 48'd0);
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    logic [127:0] prm_a;
    logic [127:0] prm_b;

    // Reset state
    #1;
    chk_all_zero("reset");
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk_all_zero("idle_after_reset");
    $display("step reset: checked");

    // Basic 20x20, no backpressure
    do_start(make_prm(10'd20, 10'd20, 4'd3, 4'd1, 4'd0, 16'd5), 1'b0, 1'b0);
    do_ack();
    run_fetch(400, 1'b0, 0, 1'b0, w);
    chk("basic_writes", w, 400);
    finish_job(1'b0);
    $display("step basic 20x20: writes=%0d", w);

    // 25x25 with backpressure and random valid
    do_start(make_prm(10'd25, 10'd25, 4'd5, 4'd2, 4'd1, 16'd64), 1'b0, 1'b0);
    do_ack();
    run_fetch(625, 1'b1, 0, 1'b0, w);
    chk("bp_writes", w, 625);
    finish_job(1'b0);
    $display("step backpressure 25x25: writes=%0d", w);

    // Zero geometry, ack not yet offered
    do_start(make_prm(10'd0, 10'd7, 4'd3, 4'd1, 4'd0, 16'd1), 1'b0, 1'b1);
    chk("zero_no_write", pix_wr_en, 1'b0);
    tick();
    chk("zero_complete_held", job_complete, 1'b1);
    chk("zero_no_request", job_fetch_request, 1'b0);
    job_complete_ack = 1'b1;
    tick();
    job_complete_ack = 1'b0;
    chk("zero_complete_cleared", job_complete, 1'b0);
    $display("step zero geometry rows=0: checked");

    // Zero geometry with ack already high: job_complete lasts one cycle
    job_complete_ack = 1'b1;
    do_start(make_prm(10'd9, 10'd0, 4'd1, 4'd1, 4'd0, 16'd2), 1'b0, 1'b1);
    tick();
    job_complete_ack = 1'b0;
    chk("zero_one_cycle_complete", job_complete, 1'b0);
    $display("step zero geometry cols=0 early ack: checked");

    // Protocol abuse: job_start held, spurious core_done/ack, params changed mid-job
    prm_a = make_prm(10'd4, 10'd4, 4'd3, 4'd1, 4'd1, 16'd7);
    prm_b = make_prm(10'd2, 10'd3, 4'd5, 4'd2, 4'd1, 16'h1234);
    do_start(prm_a, 1'b1, 1'b0);
    job_parameters = prm_b;
    do_ack();
    run_fetch(16, 1'b0, 0, 1'b1, w);
    chk("abuse_writes", w, 16);
    finish_job(1'b1);
    chk("abuse_rows_kept", cfg_rows, 10'd4);
    chk("abuse_nk_kept", cfg_num_kernels, 16'd7);
    $display("step protocol abuse: writes=%0d", w);

    // Back-to-back: start at A+1 accepted at A+2 with new parameters
    do_start(prm_b, 1'b0, 1'b0);
    do_ack();
    run_fetch(6, 1'b0, 0, 1'b0, w);
    chk("b2b_writes", w, 6);
    finish_job(1'b0);
    $display("step back-to-back: writes=%0d", w);

    // Reset mid-fetch after beat 137
    do_start(make_prm(10'd20, 10'd20, 4'd3, 4'd1, 4'd0, 16'd5), 1'b0, 1'b0);
    do_ack();
    run_fetch(400, 1'b0, 137, 1'b0, w);
    chk("pre_reset_write_seen", pix_wr_en, 1'b1);
    rst = 1'b1;
    #1;
    chk_all_zero("async_reset");
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk_all_zero("after_mid_reset");
    $display("step reset mid-fetch: beats_before_reset=%0d", w);

    do_start(make_prm(10'd20, 10'd20, 4'd3, 4'd1, 4'd0, 16'd5), 1'b0, 1'b0);
    do_ack();
    run_fetch(400, 1'b0, 0, 1'b0, w);
    chk("post_reset_writes", w, 400);
    finish_job(1'b0);
    $display("step post-reset 20x20: writes=%0d", w);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
